// File: rtl/acia_rx_fifo.sv
// Receive FIFO between the ACIA serial receiver and the register interface.
// Stores {err, data} per byte, presents the head first-word-fall-through.
module acia_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int THRESH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_dat,
  input  logic        rx_stb,
  input  logic        rx_err,
  input  logic        pop,
  input  logic        flush,
  input  logic        clr_ovr,
  output logic [7:0]  dout,
  output logic        dout_err,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        overrun,
  output logic        avail_irq
);

  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam int            DEPTH_I  = DEPTH;
  localparam int            THRESH_I = THRESH;
  localparam logic [AW:0]   CNT_FULL = DEPTH_I[AW:0];
  localparam logic [AW:0]   CNT_THR  = THRESH_I[AW:0];

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovr;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;

  // Status flags come from the registered count only, so rx_stb/pop never
  // reach an output combinationally.
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_FULL);
  assign count     = cnt;
  assign overrun   = ovr;
  assign avail_irq = (cnt >= CNT_THR);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // strobe that coincides with a pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = rx_stb & (~full | pop_ok);
  assign drop    = rx_stb & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= {rx_err, rx_dat};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      if (drop)
        ovr <= 1'b1;
      else if (clr_ovr)
        ovr <= 1'b0;
    end
  end

  always_comb begin
    dout     = 8'h00;
    dout_err = 1'b0;
    if (!empty) begin
      dout     = mem[rd_ptr][7:0];
      dout_err = mem[rd_ptr][8];
    end
  end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// Self-checking bench for acia_rx_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_acia_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic        rx_err;
  logic        pop;
  logic        flush;
  logic        clr_ovr;
  logic [7:0]  dout;
  logic        dout_err;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overrun;
  logic        avail_irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] q[$];
  logic       m_ovr;

  acia_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_err(rx_err),
    .pop(pop), .flush(flush), .clr_ovr(clr_ovr), .dout(dout),
    .dout_err(dout_err), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .avail_irq(avail_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exp_v();
    logic [8:0] head;
    logic [4:0] c;
    head = (q.size() == 0) ? 9'h000 : q[0];
    c = 5'(q.size());
    return {head[8], head[7:0], c, q.size() == 0, q.size() == DEPTH, m_ovr,
            q.size() >= THRESH};
  endfunction

  function automatic logic [17:0] obs_v();
    return {dout_err, dout, count, empty, full, overrun, avail_irq};
  endfunction

  // Reference: a pop frees a slot before the strobe is considered.
  function automatic void model_step(input logic stb, input logic [7:0] dat,
                                     input logic err, input logic p,
                                     input logic fl, input logic clr);
    logic was_full;
    logic popped;
    if (fl) begin
      q.delete();
      m_ovr = 1'b0;
      return;
    end
    was_full = (q.size() == DEPTH);
    popped = 1'b0;
    if (p && q.size() > 0) begin
      void'(q.pop_front());
      popped = 1'b1;
    end
    if (stb && (!was_full || popped))
      q.push_back({err, dat});
    if (stb && was_full && !popped)
      m_ovr = 1'b1;
    else if (clr)
      m_ovr = 1'b0;
  endfunction

  task automatic cyc(input logic stb, input logic [7:0] dat, input logic err,
                     input logic p, input logic fl, input logic clr);
    rx_stb = stb; rx_dat = dat; rx_err = err; pop = p; flush = fl; clr_ovr = clr;
    @(posedge clk);
    model_step(stb, dat, err, p, fl, clr);
    #1;
    rx_stb = 1'b0; pop = 1'b0; flush = 1'b0; clr_ovr = 1'b0;
    rx_dat = 8'h00; rx_err = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    cyc(1'b1, d, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_pop();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_stb = 1'b0; rx_dat = 8'h00; rx_err = 1'b0; pop = 1'b0;
    flush = 1'b0; clr_ovr = 1'b0;
    q.delete(); m_ovr = 1'b0;
    #2;
    n_cmp++;
    if (obs_v() !== 18'b0_00000000_00000_1_0_0_0) begin
      n_err++;
      $display("FAIL reset_state: got %h required %h", obs_v(), 18'b0_00000000_00000_1_0_0_0);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_v() !== exp_v()) begin
      n_err++;
      $display("FAIL reset_release: got %h required %h", obs_v(), exp_v());
    end
  endtask

  task automatic test_single();
    push(8'h41, 1'b0);
    n_cmp++;
    if (empty !== 1'b0 || count !== 5'd1 || dout !== 8'h41 || dout_err !== 1'b0) begin
      n_err++;
      $display("FAIL single_push: empty=%b count=%0d dout=%h err=%b required 0/1/41/0",
               empty, count, dout, dout_err);
    end
    do_pop();
    n_cmp++;
    if (empty !== 1'b1 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL single_pop: empty=%b dout=%h required 1/00", empty, dout);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    n_cmp++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL fill: full=%b count=%0d ovr=%b required 1/16/0", full, count, overrun);
    end
    push(8'hAA, 1'b0);
    n_cmp++;
    if (overrun !== 1'b1 || count !== 5'd16) begin
      n_err++;
      $display("FAIL overrun_set: ovr=%b count=%0d required 1/16", overrun, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dout !== 8'(i)) begin
        n_err++;
        $display("FAIL drain_order[%0d]: got %h required %h", i, dout, 8'(i));
      end
      do_pop();
    end
    n_cmp++;
    if (empty !== 1'b1 || dout !== 8'h00 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL drain_end: empty=%b dout=%h ovr=%b required 1/00/1", empty, dout, overrun);
    end
  endtask

  task automatic test_full_pushpop();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL clr_ovr: got %b required 0", overrun);
    end
    for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i), 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 5'd16 || overrun !== 1'b0 || dout !== 8'h81) begin
      n_err++;
      $display("FAIL full_push_pop: count=%0d ovr=%b dout=%h required 16/0/81", count, overrun, dout);
    end
    for (int i = 0; i < DEPTH - 1; i++) do_pop();
    n_cmp++;
    if (dout !== 8'h55 || count !== 5'd1) begin
      n_err++;
      $display("FAIL wrap_last: dout=%h count=%0d required 55/1", dout, count);
    end
    do_pop();
  endtask

  task automatic test_err_flag();
    push(8'h12, 1'b1);
    push(8'h34, 1'b0);
    n_cmp++;
    if (dout !== 8'h12 || dout_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_head: dout=%h err=%b required 12/1", dout, dout_err);
    end
    do_pop();
    n_cmp++;
    if (dout !== 8'h34 || dout_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_next: dout=%h err=%b required 34/0", dout, dout_err);
    end
    do_pop();
  endtask

  task automatic test_thresh_flush();
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i), 1'b0);
    n_cmp++;
    if (avail_irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_below: got %b required 0", avail_irq);
    end
    push(8'h63, 1'b0);
    n_cmp++;
    if (avail_irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_at: got %b required 1", avail_irq);
    end
    do_pop();
    n_cmp++;
    if (avail_irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_after_pop: got %b required 0", avail_irq);
    end
    for (int i = 0; i < DEPTH + 1; i++) push(8'h70, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL flush: count=%0d empty=%b ovr=%b dout=%h required 0/1/0/00",
               count, empty, overrun, dout);
    end
  endtask

  task automatic test_corner_strobes();
    cyc(1'b1, 8'h9C, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 5'd1 || dout !== 8'h9C || dout_err !== 1'b1) begin
      n_err++;
      $display("FAIL push_pop_empty: count=%0d dout=%h err=%b required 1/9c/1", count, dout, dout_err);
    end
    for (int i = 0; i < DEPTH - 1; i++) push(8'h10, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (overrun !== 1'b1 || count !== 5'd16) begin
      n_err++;
      $display("FAIL set_beats_clear: ovr=%b count=%0d required 1/16", overrun, count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < DEPTH - 5; i++) do_pop();
    n_cmp++;
    if (count !== 5'd5 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: count=%0d ovr=%b required 5/1", count, overrun);
    end
    #3 rst = 1'b0;
    q.delete(); m_ovr = 1'b0;
    #1;
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || dout !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: count=%0d empty=%b ovr=%b dout=%h required 0/1/0/00",
               count, empty, overrun, dout);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    do_pop();
    n_cmp++;
    if (obs_v() !== exp_v()) begin
      n_err++;
      $display("FAIL pop_empty: got %h required %h", obs_v(), exp_v());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int phase;
      logic s, p, f, c;
      phase = (i / 100) % 3;
      s = (phase == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
      p = (phase == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
      f = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 19) == 0);
      cyc(s, 8'($urandom), 1'($urandom), p, f, c);
      n_cmp++;
      if (obs_v() !== exp_v()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h required %h", i, obs_v(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_full_pushpop();
    test_err_flag();
    test_thresh_flush();
    test_corner_strobes();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
